sample_fifo_reader: RTL
=======================

# sample_fifo_reader

APB-side read controller for the sample FIFO that `wrapper_control` fills on each RTC-triggered ADC conversion. It pops FIFO entries on APB reads of a DATA register, exposes FIFO status and a sticky overrun flag, and raises a level/overrun interrupt. It sits between the sample FIFO read port and the system APB bus, in the same clock domain as `wrapper_control`.

## Interface
- `DATA_W`, 16: sample width; zero-extended into 32-bit `prdata`.
- `LVL_W`, 8: width of FIFO fill level and IRQ threshold.
- `clk` in 1: single clock for FIFO, FSM and APB.
- `rst` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1 each: APB control.
- `paddr` in 4: byte address; decode uses `paddr[3:2]`.
- `pwdata` in 32: APB write data.
- `prdata` out 32: APB read data.
- `pready` out 1: APB ready.
- `pslverr` out 1: APB error.
- `fifo_rd_en` out 1: one-cycle pop strobe.
- `fifo_rd_data` in DATA_W: FIFO output, valid one cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_full` in 1: FIFO full flag.
- `fifo_level` in LVL_W: current FIFO occupancy.
- `apb_fifo_ready` in 1: full-error pulse from `wrapper_control`; sets overrun.
- `irq` out 1: interrupt, registered.

## Operation
- Register map:
  - 0x0 DATA: RO; a read pops one sample.
  - 0x4 STATUS: RO; bit0 empty, bit1 full, bit2 overrun, bits[8+LVL_W-1:8] level.
  - 0x8 CTRL: RW; bit0 irq_en, bits[8+LVL_W-1:8] threshold.
  - 0xC CLEAR: WO; writing 1 to bit2 clears overrun.
- FSM states:
  - IDLE: handles all accesses except a DATA read with `!fifo_empty`. That read asserts `fifo_rd_en` combinationally for this one access cycle, with `pready`=0, then goes to POP.
  - POP: captures `fifo_rd_data` into a hold register; `pready`=0; goes to RESP.
  - RESP: `pready`=1, `prdata` = zero-extended hold register; returns to IDLE.
- DATA read when empty: no pop, `pready`=1 in the first access cycle, `prdata`=0, `pslverr`=1.
- Non-DATA accesses: zero wait states; `pslverr`=0. Writes to RO registers are ignored without error.
- Overrun flag:
  - Set on any cycle with `apb_fifo_ready`=1.
  - Cleared by a CLEAR write with bit2=1.
  - Set and clear in the same cycle: set wins.
- `irq` next value = irq_en & (overrun | (threshold != 0 & fifo_level >= threshold)). Threshold 0 disables the level term.

## Timing
- Reset values: `prdata` 0, `pready` 0, `pslverr` 0, `fifo_rd_en` 0, `irq` 0, CTRL 0, overrun 0, FSM IDLE.
- `pready`, `pslverr` and `fifo_rd_en` are 0 whenever `psel`=0. `prdata` is 0 outside a completing read.
- Latencies:
  - Non-empty DATA read: 2 wait states (3 access cycles). Exactly one `fifo_rd_en` pulse per read.
  - Other accesses: 0 wait states.
  - `irq`: one cycle after its condition changes.
- A fifo_level/fifo_empty change during POP or RESP does not alter the read in progress.
- Reset asserted mid-read returns the FSM to IDLE immediately. The popped sample is discarded; no second pop occurs.
- Back-to-back DATA reads pop consecutive samples with no lost or duplicated entries.

## Configuration
- `SAMPLE_FIFO_READER_IRQ_EN` defined: CTRL register and `irq` logic are compiled in as described.
- Macro undefined:
  - `irq` is tied to 0.
  - CTRL reads 0 and ignores writes.
  - The overrun flag and CLEAR register remain.

## Structure
- Shared package `sample_fifo_pkg` holds:
  - register offsets (DATA/STATUS/CTRL/CLEAR);
  - STATUS/CTRL bit positions;
  - the FSM state enum (IDLE/POP/RESP).
- One sub-module: `sample_fifo_reader_regs`, containing CTRL, overrun and the irq logic. The FSM and APB decode stay in the top module.

## Test plan
- Read with FIFO holding 0x0123, 0x0456: two DATA reads -> `prdata`=0x00000123 then 0x00000456. One `fifo_rd_en` each; `pready` high on the 3rd access cycle.
- Empty FIFO DATA read -> `pready`=1 in the first access cycle, `pslverr`=1, `prdata`=0, no `fifo_rd_en`.
- Pulse `apb_fifo_ready` for 1 cycle -> STATUS bit2=1.
  - Write 0x4 to CLEAR -> bit2=0.
  - Pulse and CLEAR in the same cycle -> bit2 stays 1.
- CTRL=0x0301 (irq_en=1, threshold=3), with `fifo_level` stepping 2 -> 3 -> `irq` rises one cycle after level=3. Pop to level 2 -> `irq` falls.
- Assert `rst` low during POP -> FSM IDLE, `pready`=0. The next DATA read pops the following sample.
- With macro undefined: CTRL write 0x0301, then read -> 0; `irq` stays 0 with overrun set.

Source files
------------

// File: rtl/sample_fifo_pkg.sv
// Shared definitions for the sample FIFO reader: APB register offsets
// (decoded from paddr[3:2]), STATUS/CTRL/CLEAR bit positions and the
// read-controller FSM state encoding.
package sample_fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    localparam int unsigned ST_EMPTY_BIT    = 0;
    localparam int unsigned ST_FULL_BIT     = 1;
    localparam int unsigned ST_OVR_BIT      = 2;
    localparam int unsigned ST_LVL_LSB      = 8;

    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_THR_LSB    = 8;

    localparam int unsigned CLR_OVR_BIT     = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sample_fifo_reader_regs.sv
// Control/status registers of the sample FIFO reader: sticky overrun flag,
// CTRL (irq_en, level threshold) and the registered interrupt.
// Optional feature macro: SAMPLE_FIFO_READER_IRQ_EN (CTRL + irq logic);
// without it CTRL reads 0 and irq_o is tied low, the overrun flag remains.
// Ports:
//   clk, rst        - clock, async active-low reset
//   ctrl_wr_i       - CTRL write strobe (completing APB write)
//   clear_wr_i      - CLEAR write strobe
//   wdata_i         - APB write data
//   ovr_set_i       - overrun set pulse from the FIFO writer
//   level_i         - current FIFO occupancy
//   ctrl_rdata_o    - CTRL read value
//   overrun_o       - sticky overrun flag
//   irq_o           - interrupt (registered)
module sample_fifo_reader_regs
    import sample_fifo_pkg::*;
#(
    parameter int unsigned LVL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_wr_i,
    input  logic             clear_wr_i,
    input  logic [31:0]      wdata_i,
    input  logic             ovr_set_i,
    input  logic [LVL_W-1:0] level_i,
    output logic [31:0]      ctrl_rdata_o,
    output logic             overrun_o,
    output logic             irq_o
);

    logic ovr_q, ovr_d;

    // Set has priority over a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        if (clear_wr_i && wdata_i[CLR_OVR_BIT]) ovr_d = 1'b0;
        if (ovr_set_i)                          ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovr_q <= 1'b0;
        else      ovr_q <= ovr_d;
    end

    assign overrun_o = ovr_q;

`ifdef SAMPLE_FIFO_READER_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic [LVL_W-1:0] thr_q, thr_d;
    logic             irq_q, irq_d;

    // CTRL update and irq condition; threshold 0 disables the level term.
    always_comb begin
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        if (ctrl_wr_i) begin
            irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
            thr_d    = wdata_i[CTRL_THR_LSB +: LVL_W];
        end
        irq_d = irq_en_q & (ovr_q | ((thr_q != '0) & (level_i >= thr_q)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        ctrl_rdata_o                            = '0;
        ctrl_rdata_o[CTRL_IRQ_EN_BIT]           = irq_en_q;
        ctrl_rdata_o[CTRL_THR_LSB +: LVL_W]     = thr_q;
    end

    assign irq_o = irq_q;

    logic unused_wdata;
    assign unused_wdata = ^{wdata_i[1], wdata_i[7:3], wdata_i[31:CTRL_THR_LSB+LVL_W]};
`else
    assign ctrl_rdata_o = '0;
    assign irq_o        = 1'b0;

    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_wr_i, level_i, wdata_i[31:3], wdata_i[1:0]};
`endif

endmodule

// File: rtl/sample_fifo_reader.sv
// APB read controller for the sample FIFO. DATA reads pop one sample
// (two wait states), STATUS/CTRL/CLEAR are zero-wait. An empty DATA read
// completes immediately with pslverr.
// Optional feature macro: SAMPLE_FIFO_READER_IRQ_EN (see regs sub-module).
// Ports:
//   clk, rst                    - clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata, prdata/pready/pslverr - APB slave
//   fifo_rd_en                  - one-cycle pop strobe
//   fifo_rd_data                - FIFO output, valid the cycle after the pop
//   fifo_empty/fifo_full/fifo_level - FIFO status
//   apb_fifo_ready              - overrun pulse from the FIFO writer
//   irq                         - interrupt (registered)
module sample_fifo_reader
    import sample_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LVL_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              apb_fifo_ready,
    output logic              irq
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              access;
    logic [1:0]        reg_sel;
    logic [31:0]       status;
    logic [31:0]       ctrl_rdata;
    logic              overrun;
    logic              ctrl_wr;
    logic              clear_wr;

    assign access  = psel & penable;
    assign reg_sel = paddr[3:2];

    always_comb begin
        status               = '0;
        status[ST_EMPTY_BIT] = fifo_empty;
        status[ST_FULL_BIT]  = fifo_full;
        status[ST_OVR_BIT]   = overrun;
        status[ST_LVL_LSB +: LVL_W] = fifo_level;
    end

    // Next state and APB/FIFO outputs; only a non-empty DATA read leaves IDLE.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        fifo_rd_en = 1'b0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata     = '0;
        ctrl_wr    = 1'b0;
        clear_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (!pwrite && (reg_sel == REG_DATA) && !fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_d    = S_POP;
                    end else begin
                        pready = 1'b1;
                        if (pwrite) begin
                            ctrl_wr  = (reg_sel == REG_CTRL);
                            clear_wr = (reg_sel == REG_CLEAR);
                        end else begin
                            case (reg_sel)
                                REG_DATA:   pslverr = 1'b1;
                                REG_STATUS: prdata  = status;
                                REG_CTRL:   prdata  = ctrl_rdata;
                                default:    prdata  = '0;
                            endcase
                        end
                    end
                end
            end
            S_POP: begin
                hold_d  = fifo_rd_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                pready  = psel;
                if (psel) prdata = 32'(hold_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    sample_fifo_reader_regs #(
        .LVL_W (LVL_W)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .ctrl_wr_i    (ctrl_wr),
        .clear_wr_i   (clear_wr),
        .wdata_i      (pwdata),
        .ovr_set_i    (apb_fifo_ready),
        .level_i      (fifo_level),
        .ctrl_rdata_o (ctrl_rdata),
        .overrun_o    (overrun),
        .irq_o        (irq)
    );

    logic unused_paddr;
    assign unused_paddr = ^paddr[1:0];

endmodule
